// File: rtl/fp_mult_pkg.sv
// Shared types, flag positions and constant helpers for the pipelined FP multiplier.
package fp_mult_pkg;

  // Operand classes after exponent-zero operands are flushed to signed zero
  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_NORM = 3'd1,
    CLS_INF  = 3'd2,
    CLS_QNAN = 3'd3,
    CLS_SNAN = 3'd4
  } fp_class_e;

  // Bit positions inside the 4-bit per-result flag vector
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX  = 0;

  // Exponent bias for a given exponent field width
  function automatic int BIAS(input int exp_w);
    return int'((32'd1 << (exp_w - 1)) - 32'd1);
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set
  function automatic logic [63:0] QNAN(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa with guard/round/sticky bits.
module fp_round_rne
  import fp_mult_pkg::*;
#(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0] mant,
  input  logic           guard,
  input  logic           round,
  input  logic           sticky,
  output logic [MAN_W:0] mant_out,
  output logic           carry,
  output logic           inexact
);

  logic             round_up_s;
  logic [MAN_W+1:0] sum_s;

  // Increment on above-half or on an exact tie with an odd LSB; renormalise a carry-out
  always_comb begin
    round_up_s = guard & (round | sticky | mant[0]);
    sum_s      = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, round_up_s};
    carry      = sum_s[MAN_W+1];
    inexact    = guard | round | sticky;
    if (carry) begin
      mant_out = sum_s[MAN_W+1:1];
    end else begin
      mant_out = sum_s[MAN_W:0];
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Four-stage pipelined floating-point multiplier with valid/ready flow control,
// RNE rounding, DAZ/FTZ, special-value handling and a pass-through tag.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS(EXP_W));
  localparam logic signed [EW-1:0] EMAX_S = EW'((32'd1 << EXP_W) - 32'd1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(32'sd1);
  localparam logic signed [EW-1:0] ZERO_S = EW'(32'sd0);
  localparam logic [W-1:0]         QNAN_V = W'(QNAN(EXP_W, MAN_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    fp_class_e c;
    if (e == {EXP_W{1'b0}}) begin
      c = CLS_ZERO;
    end else if (e != {EXP_W{1'b1}}) begin
      c = CLS_NORM;
    end else if (f == {MAN_W{1'b0}}) begin
      c = CLS_INF;
    end else if (f[MAN_W-1]) begin
      c = CLS_QNAN;
    end else begin
      c = CLS_SNAN;
    end
    return c;
  endfunction

  // ---------------- handshake ----------------
  logic v1_r, v2_r, v3_r, out_valid_r, init_r;
  logic rdy1_s, rdy2_s, rdy3_s, rdy4_s, take_s;

  // A stage may load when it is empty or its content moves on this cycle
  always_comb begin
    rdy4_s   = !out_valid_r || out_ready;
    rdy3_s   = !v3_r || rdy4_s;
    rdy2_s   = !v2_r || rdy3_s;
    rdy1_s   = !v1_r || rdy2_s;
    in_ready = init_r && rdy1_s;
    take_s   = in_valid && in_ready;
  end

  // Hold off accepting operands until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) init_r <= 1'b0;
    else          init_r <= 1'b1;
  end

  // ---------------- S1: unpack / classify ----------------
  logic [EXP_W-1:0]     exp_a_s, exp_b_s;
  logic [MAN_W-1:0]     frac_a_s, frac_b_s;
  fp_class_e            cls_a_s, cls_b_s;
  logic                 sign_s, nan_any_s, snan_any_s, inf_any_s, zero_any_s;
  logic signed [EW-1:0] exp_sum_s;
  logic                 spec_s;
  logic [W-1:0]         spec_res_s;
  logic [3:0]           spec_flg_s;

  // Classify operands and resolve special-case results ahead of the datapath
  always_comb begin
    exp_a_s    = in_a[W-2:MAN_W];
    exp_b_s    = in_b[W-2:MAN_W];
    frac_a_s   = in_a[MAN_W-1:0];
    frac_b_s   = in_b[MAN_W-1:0];
    cls_a_s    = classify(exp_a_s, frac_a_s);
    cls_b_s    = classify(exp_b_s, frac_b_s);
    sign_s     = in_a[W-1] ^ in_b[W-1];
    exp_sum_s  = $signed({2'b00, exp_a_s}) + $signed({2'b00, exp_b_s}) - BIAS_S;
    snan_any_s = (cls_a_s == CLS_SNAN) || (cls_b_s == CLS_SNAN);
    nan_any_s  = snan_any_s || (cls_a_s == CLS_QNAN) || (cls_b_s == CLS_QNAN);
    inf_any_s  = (cls_a_s == CLS_INF) || (cls_b_s == CLS_INF);
    zero_any_s = (cls_a_s == CLS_ZERO) || (cls_b_s == CLS_ZERO);
    spec_s     = 1'b0;
    spec_res_s = {W{1'b0}};
    spec_flg_s = 4'b0000;
    if (nan_any_s) begin
      spec_s              = 1'b1;
      spec_res_s          = QNAN_V;
      spec_flg_s[FLG_INV] = snan_any_s;
    end else if (inf_any_s && zero_any_s) begin
      spec_s              = 1'b1;
      spec_res_s          = QNAN_V;
      spec_flg_s[FLG_INV] = 1'b1;
    end else if (inf_any_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_any_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {(W - 1){1'b0}}};
    end else begin
      spec_s = 1'b0;
    end
  end

  logic [TAG_W-1:0]     tag1_r, tag2_r, tag3_r;
  logic                 sign1_r, sign2_r, sign3_r;
  logic signed [EW-1:0] exp1_r, exp2_r, exp3_r;
  logic [MAN_W:0]       ma1_r, mb1_r, mant3_r;
  logic [PW-1:0]        prod2_r;
  logic                 spec1_r, spec2_r, spec3_r;
  logic [W-1:0]         sres1_r, sres2_r, sres3_r;
  logic [3:0]           sflg1_r, sflg2_r, sflg3_r;
  logic                 grd3_r, rnd3_r, stk3_r;

  // S1 register: capture operands, hidden-bit mantissas and the special-case verdict
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r <= 1'b0; tag1_r <= {TAG_W{1'b0}}; sign1_r <= 1'b0; exp1_r <= ZERO_S;
      ma1_r <= {(MAN_W + 1){1'b0}}; mb1_r <= {(MAN_W + 1){1'b0}};
      spec1_r <= 1'b0; sres1_r <= {W{1'b0}}; sflg1_r <= 4'b0000;
    end else if (rdy1_s) begin
      v1_r <= take_s;
      if (take_s) begin
        tag1_r <= in_tag; sign1_r <= sign_s; exp1_r <= exp_sum_s;
        ma1_r <= {1'b1, frac_a_s}; mb1_r <= {1'b1, frac_b_s};
        spec1_r <= spec_s; sres1_r <= spec_res_s; sflg1_r <= spec_flg_s;
      end
    end
  end

  // ---------------- S2: mantissa product ----------------
  // S2 register: full-width mantissa product
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_r <= 1'b0; tag2_r <= {TAG_W{1'b0}}; sign2_r <= 1'b0; exp2_r <= ZERO_S;
      prod2_r <= {PW{1'b0}}; spec2_r <= 1'b0; sres2_r <= {W{1'b0}}; sflg2_r <= 4'b0000;
    end else if (rdy2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        tag2_r <= tag1_r; sign2_r <= sign1_r; exp2_r <= exp1_r;
        prod2_r <= ma1_r * mb1_r;
        spec2_r <= spec1_r; sres2_r <= sres1_r; sflg2_r <= sflg1_r;
      end
    end
  end

  // ---------------- S3: normalise / GRS ----------------
  logic [MAN_W:0]       mant_n_s;
  logic                 grd_n_s, rnd_n_s, stk_n_s;
  logic signed [EW-1:0] exp_n_s;

  // Product lies in [1,4): shift by one when the MSB is set and bump the exponent
  always_comb begin
    if (prod2_r[PW-1]) begin
      mant_n_s = prod2_r[PW-1:MAN_W+1];
      grd_n_s  = prod2_r[MAN_W];
      rnd_n_s  = prod2_r[MAN_W-1];
      stk_n_s  = |prod2_r[MAN_W-2:0];
      exp_n_s  = exp2_r + ONE_S;
    end else begin
      mant_n_s = prod2_r[PW-2:MAN_W];
      grd_n_s  = prod2_r[MAN_W-1];
      rnd_n_s  = prod2_r[MAN_W-2];
      stk_n_s  = |prod2_r[MAN_W-3:0];
      exp_n_s  = exp2_r;
    end
  end

  // S3 register: normalised mantissa plus guard/round/sticky
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v3_r <= 1'b0; tag3_r <= {TAG_W{1'b0}}; sign3_r <= 1'b0; exp3_r <= ZERO_S;
      mant3_r <= {(MAN_W + 1){1'b0}}; grd3_r <= 1'b0; rnd3_r <= 1'b0; stk3_r <= 1'b0;
      spec3_r <= 1'b0; sres3_r <= {W{1'b0}}; sflg3_r <= 4'b0000;
    end else if (rdy3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        tag3_r <= tag2_r; sign3_r <= sign2_r; exp3_r <= exp_n_s;
        mant3_r <= mant_n_s; grd3_r <= grd_n_s; rnd3_r <= rnd_n_s; stk3_r <= stk_n_s;
        spec3_r <= spec2_r; sres3_r <= sres2_r; sflg3_r <= sflg2_r;
      end
    end
  end

  // ---------------- S4: round / exceptions / pack ----------------
  logic [MAN_W:0]       rmant_s;
  logic                 rcarry_s, rnx_s;
  logic signed [EW-1:0] exp_r_s;
  logic [W-1:0]         res4_s;
  logic [3:0]           flg4_s;

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .mant     (mant3_r),
    .guard    (grd3_r),
    .round    (rnd3_r),
    .sticky   (stk3_r),
    .mant_out (rmant_s),
    .carry    (rcarry_s),
    .inexact  (rnx_s)
  );

  // Apply rounding carry to the exponent, then pick special, overflow, underflow or normal result
  always_comb begin
    exp_r_s = rcarry_s ? (exp3_r + ONE_S) : exp3_r;
    res4_s  = {W{1'b0}};
    flg4_s  = 4'b0000;
    if (spec3_r) begin
      res4_s = sres3_r;
      flg4_s = sflg3_r;
    end else if (exp_r_s >= EMAX_S) begin
      res4_s          = {sign3_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg4_s[FLG_OVF] = 1'b1;
      flg4_s[FLG_NX]  = 1'b1;
    end else if (exp_r_s <= ZERO_S || !rmant_s[MAN_W]) begin
      // a missing hidden bit can only mean a subnormal; flush it like any underflow
      res4_s          = {sign3_r, {(W - 1){1'b0}}};
      flg4_s[FLG_UNF] = 1'b1;
      flg4_s[FLG_NX]  = 1'b1;
    end else begin
      res4_s         = {sign3_r, exp_r_s[EXP_W-1:0], rmant_s[MAN_W-1:0]};
      flg4_s[FLG_NX] = rnx_s;
    end
  end

  logic [W-1:0]     res_r;
  logic [TAG_W-1:0] tag4_r;
  logic [3:0]       flg_r;

  // S4 register drives the outputs; contents hold while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0; res_r <= {W{1'b0}}; tag4_r <= {TAG_W{1'b0}}; flg_r <= 4'b0000;
    end else if (rdy4_s) begin
      out_valid_r <= v3_r;
      if (v3_r) begin
        res_r <= res4_s; tag4_r <= tag3_r; flg_r <= flg4_s;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_result = res_r;
  assign out_tag    = tag4_r;
  assign out_flags  = flg_r;

endmodule
